// File: rtl/video_axis_pkg.sv
// Shared types for the video-to-AXI4-Stream bridge: FSM state encoding, FIFO word layout
// and the FIFO address-width helper.
package video_axis_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_VSYNC = 2'd0,
        ST_ACTIVE     = 2'd1,
        ST_DROP       = 2'd2
    } bridge_state_t;

    // Sideband bits carried above the pixel in every FIFO word, most significant first.
    typedef struct packed {
        logic sof;
        logic eol;
    } fifo_tag_t;

    localparam int VID_DATA_WIDTH = 24;

    // Reference layout of one buffered beat at the default RGB888 pixel width.
    typedef struct packed {
        logic                      sof;
        logic                      eol;
        logic [VID_DATA_WIDTH-1:0] data;
    } fifo_word_t;

    function automatic int fifo_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/video_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is visible on rd_data while not empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module video_sync_fifo
    import video_axis_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = fifo_addr_width(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/video_to_axis_bridge.sv
// Parallel video (vsync/de/data) to AXI4-Stream bridge: frame lock FSM, sof/eol tagging, FWFT buffer.
// Define VID_BRIDGE_FMT_CHECK_EN for geometry checking (fmt_err) and release of the lock at frame end.
module video_to_axis_bridge
    import video_axis_pkg::*;
#(
    parameter int WIDTH       = 1920,
    parameter int HEIGHT      = 1080,
    parameter int DATA_WIDTH  = 24,
    parameter int COORD_WIDTH = 16,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vid_vsync,
    input  logic                  vid_hsync,
    input  logic                  vid_de,
    input  logic [DATA_WIDTH-1:0] vid_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic                  overflow,
    output logic                  fmt_err,
    output logic [15:0]           frame_cnt
);
    localparam int WORD_W = DATA_WIDTH + 2;
    localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(WIDTH - 1);

    typedef struct packed {
        fifo_tag_t             tag;
        logic [DATA_WIDTH-1:0] data;
    } word_t;

    // Stream handshake: a beat moves on a clock edge where tvalid and tready are both high;
    // tvalid comes only from FIFO occupancy, and the payload reads as zero while tvalid is low.

    logic                   r_vsync, r_vsync_d, r_de, r_de_d;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   vsync_rise, de_fall;
    bridge_state_t          state, state_next;
    logic [COORD_WIDTH-1:0] x, y;
    logic                   sof_pending;
    logic                   p_valid;
    word_t                  p_word;
    word_t                  head_word;
    logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic                   wr_attempt, push_blocked, stage_pix;
    logic                   overflow_q;
    logic [15:0]            frame_cnt_q;
    logic                   unused_hsync;

    assign unused_hsync = vid_hsync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync   <= 1'b0;
            r_vsync_d <= 1'b0;
            r_de      <= 1'b0;
            r_de_d    <= 1'b0;
            r_data    <= '0;
        end else begin
            r_vsync   <= vid_vsync;
            r_vsync_d <= r_vsync;
            r_de      <= vid_de;
            r_de_d    <= r_de;
            r_data    <= vid_data;
        end
    end

    assign vsync_rise = r_vsync & ~r_vsync_d;
    assign de_fall    = ~r_de & r_de_d;

    // The staged word is written one cycle after it is tagged; a write refused for lack of
    // space breaks the stream, so the FSM drops everything until the next frame.
    assign fifo_pop     = ~fifo_empty & m_axis_tready;
    assign wr_attempt   = p_valid & (state != ST_DROP);
    assign push_blocked = wr_attempt & fifo_full & ~fifo_pop;
    assign fifo_push    = wr_attempt & ~push_blocked;
    assign stage_pix    = (state == ST_ACTIVE) & r_de & ~vsync_rise & ~push_blocked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT_VSYNC;
        end else begin
            state <= state_next;
        end
    end

`ifdef VID_BRIDGE_FMT_CHECK_EN
    localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(HEIGHT - 1);
    localparam logic [COORD_WIDTH-1:0] Y_END  = COORD_WIDTH'(HEIGHT);

    logic frame_done_pix;
    logic fmt_hit;
    logic fmt_err_q;

    assign frame_done_pix = stage_pix & (x == X_LAST) & (y == Y_LAST);

    // y parks at HEIGHT once a frame completes, which distinguishes trailing pixels from
    // pixels that merely precede the first vsync after reset.
    assign fmt_hit = ((state == ST_ACTIVE) & de_fall & (x != '0))
                   | ((state == ST_ACTIVE) & vsync_rise & (y != Y_END))
                   | ((state == ST_WAIT_VSYNC) & r_de & ~vsync_rise & (y == Y_END));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmt_err_q <= 1'b0;
        end else if (fmt_hit) begin
            fmt_err_q <= 1'b1;
        end
    end

    assign fmt_err = fmt_err_q;
`else
    localparam int unused_height = HEIGHT;

    logic frame_done_pix;

    assign frame_done_pix = 1'b0;
    assign fmt_err        = 1'b0;
`endif

    always_comb begin
        state_next = state;
        if (vsync_rise) begin
            state_next = ST_ACTIVE;
        end else if ((state == ST_ACTIVE) && push_blocked) begin
            state_next = ST_DROP;
        end else if (frame_done_pix) begin
            state_next = ST_WAIT_VSYNC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            sof_pending <= 1'b0;
            frame_cnt_q <= '0;
            p_valid     <= 1'b0;
            p_word      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            p_valid <= stage_pix;
            if (push_blocked) begin
                overflow_q <= 1'b1;
            end
            if (vsync_rise) begin
                x           <= '0;
                y           <= '0;
                sof_pending <= 1'b1;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end else if (stage_pix) begin
                p_word.tag.sof <= sof_pending;
                p_word.tag.eol <= (x == X_LAST);
                p_word.data    <= r_data;
                sof_pending    <= 1'b0;
                if (x == X_LAST) begin
                    x <= '0;
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    video_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (p_word),
        .pop     (fifo_pop),
        .rd_data (head_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : head_word.data;
    assign m_axis_tlast  = ~fifo_empty & head_word.tag.eol;
    assign m_axis_tuser  = ~fifo_empty & head_word.tag.sof;
    assign overflow      = overflow_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_video_to_axis_bridge.sv
// Directed bench for video_to_axis_bridge on an 8x4 frame with a 16-entry FIFO.
// Expected fmt_err follows VID_BRIDGE_FMT_CHECK_EN as seen by this file.
module tb_video_to_axis_bridge;
    localparam int W     = 8;
    localparam int H     = 4;
    localparam int DW    = 24;
    localparam int DEPTH = 16;
    localparam int BW    = DW + 2;
`ifdef VID_BRIDGE_FMT_CHECK_EN
    localparam logic FMT_ON = 1'b1;
`else
    localparam logic FMT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vid_vsync = 1'b0;
    logic          vid_hsync = 1'b0;
    logic          vid_de = 1'b0;
    logic [DW-1:0] vid_data = '0;
    logic          m_axis_tready = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic          overflow, fmt_err;
    logic [15:0]   frame_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_de_cyc = -1;
    int first_valid_cyc = -1;
    int pix_driven = 0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] obs_q[$];

    video_to_axis_bridge #(
        .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .COORD_WIDTH(16), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .vid_vsync(vid_vsync), .vid_hsync(vid_hsync), .vid_de(vid_de), .vid_data(vid_data),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tready(m_axis_tready),
        .overflow(overflow), .fmt_err(fmt_err), .frame_cnt(frame_cnt)
    );

    // Clock and cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: a beat seen valid&ready at the negedge transfers on the next posedge
    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) obs_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
        if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        vid_vsync = 1'b0; vid_de = 1'b0; vid_hsync = 1'b0; vid_data = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_frame(input int base, input int short_line, input int short_len);
        int idx = 0;
        vid_vsync = 1'b1;
        repeat (2) tick();
        vid_vsync = 1'b0;
        repeat (3) tick();
        for (int l = 0; l < H; l++) begin
            for (int p = 0; p < ((l == short_line) ? short_len : W); p++) begin
                if (first_de_cyc < 0) first_de_cyc = cyc;
                vid_de = 1'b1;
                vid_data = DW'(base + idx);
                idx++;
                pix_driven++;
                tick();
            end
            vid_de = 1'b0;
            vid_hsync = 1'b1;
            tick();
            vid_hsync = 1'b0;
            repeat (2) tick();
        end
        repeat (2) tick();
    endtask

    task automatic build_exp(input int base, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back({(i == 0), ((i % W) == W - 1), DW'(base + i)});
    endtask

    // Tests
    task automatic test_reset();
        apply_reset();
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== '0) begin
            errors++;
            $display("FAIL reset_stream got %b %b %b %h exp all 0", m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata);
        end
        checks++;
        if ({overflow, fmt_err} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags got %b%b exp 00", overflow, fmt_err);
        end
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt);
        end
    endtask

    task automatic test_clean_frame();
        obs_q.delete();
        m_axis_tready = 1'b1;
        first_de_cyc = -1;
        first_valid_cyc = -1;
        send_frame(0, -1, 0);
        repeat (10) tick();
        build_exp(0, 32);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL clean_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL clean_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        // de is sampled at the edge after it is driven; tvalid follows two edges later
        checks++;
        if (first_valid_cyc != first_de_cyc + 3) begin
            errors++;
            $display("FAIL clean_latency got %0d exp %0d", first_valid_cyc - first_de_cyc, 3);
        end
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL clean_frame_cnt got %0d exp 1", frame_cnt);
        end
        checks++;
        if ({overflow, fmt_err} !== 2'b00) begin
            errors++;
            $display("FAIL clean_flags got %b%b exp 00", overflow, fmt_err);
        end
    endtask

    task automatic test_stall();
        logic [BW:0] held;
        obs_q.delete();
        m_axis_tready = 1'b1;
        fork
            send_frame(100, -1, 0);
            begin
                repeat (19) tick();
                m_axis_tready = 1'b0;
                @(negedge clk);
                held = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata};
                checks++;
                if (held[BW] !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_valid got %b exp 1", held[BW]);
                end
                repeat (9) begin
                    @(negedge clk);
                    checks++;
                    if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata} !== held) begin
                        errors++;
                        $display("FAIL stall_hold got %h exp %h", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, held);
                    end
                end
                tick();
                m_axis_tready = 1'b1;
            end
        join
        repeat (20) tick();
        build_exp(100, 32);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stall_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({frame_cnt, overflow, fmt_err} !== {16'd2, 2'b00}) begin
            errors++;
            $display("FAIL stall_status got cnt %0d flags %b%b exp cnt 2 flags 00", frame_cnt, overflow, fmt_err);
        end
    endtask

    task automatic test_overflow();
        obs_q.delete();
        m_axis_tready = 1'b0;
        send_frame(200, -1, 0);
        repeat (3) tick();
        checks++;
        if ({m_axis_tvalid, overflow} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_flag got valid %b overflow %b exp 1 1", m_axis_tvalid, overflow);
        end
        m_axis_tready = 1'b1;
        repeat (25) tick();
        build_exp(200, DEPTH);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL ovf_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ovf_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        send_frame(300, -1, 0);
        repeat (10) tick();
        build_exp(300, 32);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL recover_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL recover_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b exp 1", overflow);
        end
    endtask

    task automatic test_short_line();
        apply_reset();
        obs_q.delete();
        m_axis_tready = 1'b1;
        send_frame(400, 2, 6);
        repeat (10) tick();
        // 30 pixels; the short line shifts the column count so eol lands on 7, 15 and 23
        exp_q.delete();
        for (int i = 0; i < 30; i++) exp_q.push_back({(i == 0), (i == 7 || i == 15 || i == 23), DW'(400 + i)});
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL short_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL short_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({fmt_err, overflow} !== {FMT_ON, 1'b0}) begin
            errors++;
            $display("FAIL short_flags got fmt %b ovf %b exp fmt %b ovf 0", fmt_err, overflow, FMT_ON);
        end
    endtask

    task automatic test_pre_vsync();
        apply_reset();
        obs_q.delete();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vid_de = 1'b1;
            vid_data = DW'(24'hABC000 + i);
            tick();
        end
        vid_de = 1'b0;
        repeat (6) tick();
        checks++;
        if (obs_q.size() != 0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL prevsync_quiet got %0d beats valid %b exp 0 beats valid 0", obs_q.size(), m_axis_tvalid);
        end
        send_frame(500, -1, 0);
        repeat (10) tick();
        build_exp(500, 32);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL prevsync_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL prevsync_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({frame_cnt, fmt_err} !== {16'd1, 1'b0}) begin
            errors++;
            $display("FAIL prevsync_status got cnt %0d fmt %b exp cnt 1 fmt 0", frame_cnt, fmt_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        obs_q.delete();
        m_axis_tready = 1'b1;
        pix_driven = 0;
        fork
            send_frame(600, -1, 0);
            begin
                for (int n = 0; n < 200 && pix_driven < 12; n++) @(negedge clk);
                checks++;
                if (pix_driven < 12) begin
                    errors++;
                    $display("FAIL midrst_reach got %0d exp 12", pix_driven);
                end
                rst_n = 1'b0;
                #1;
                checks++;
                if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, frame_cnt} !== '0) begin
                    errors++;
                    $display("FAIL midrst_clear got valid %b data %h cnt %0d exp 0 0 0", m_axis_tvalid, m_axis_tdata, frame_cnt);
                end
                obs_q.delete();
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (10) tick();
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_quiet got %0d beats exp 0", obs_q.size());
        end
        send_frame(700, -1, 0);
        repeat (10) tick();
        build_exp(700, 32);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL midrst_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midrst_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL midrst_frame_cnt got %0d exp 1", frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_stall();
        test_overflow();
        test_short_line();
        test_pre_vsync();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
